instr_fetch_unit: RTL

//  Fetch stage of the multicycle CPU; the requesting side of the instruction-memory read port.
//  - Owns the program counter and drives it to instruction memory, which is a combinational,

---
 rtl/instr_fetch_unit_if.sv | 40 ++++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the signals between the fetch unit, the control FSM and the
// instruction memory read port.
//   fetch_req   control -> fetch : start one fetch
//   pc_we       control -> fetch : load PC according to pc_sel
//   pc_sel      control -> fetch : 00 hold, 01 branch, 10 jump, 11 hold
//   imem_pc     fetch   -> IMem  : word address (the PC register)
//   imem_instr  IMem    -> fetch : instruction at imem_pc (combinational ROM)
//   ir          fetch   -> ctrl  : instruction register
//   ir_pc       fetch   -> ctrl  : address the current IR came from
//   ir_valid    fetch   -> ctrl  : one-cycle pulse when IR is updated
//   busy        fetch   -> ctrl  : fetch in flight
//   err         fetch   -> ctrl  : sticky protocol-violation flag
// Modports: slave = fetch unit, master = control FSM / IMem side.
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH = 16
);
  logic                fetch_req;
  logic                pc_we;
  logic [1:0]          pc_sel;
  logic [PC_WIDTH-1:0] imem_pc;
  logic [31:0]         imem_instr;
  logic [31:0]         ir;
  logic [PC_WIDTH-1:0] ir_pc;
  logic                ir_valid;
  logic                busy;
  logic                err;

  modport slave (
    input  fetch_req, pc_we, pc_sel, imem_instr,
    output imem_pc, ir, ir_pc, ir_valid, busy, err
  );

  modport master (
    output fetch_req, pc_we, pc_sel, imem_instr,
    input  imem_pc, ir, ir_pc, ir_valid, busy, err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage of the multicycle CPU. Owns the PC, presents it to a
// combinational word-addressed IMem, waits FETCH_WAIT extra cycles, then
// captures the instruction into the IR and advances the PC. Branch/jump
// redirects are applied when the control FSM asserts pc_we while idle.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    instr_fetch_unit_if.slave (handshake, IMem port, IR outputs)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int PC_WIDTH   = 16,
  parameter int FETCH_WAIT = 0,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_unit_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [PC_WIDTH-1:0] ir_pc_q, ir_pc_d;
  logic                ir_valid_q, ir_valid_d;
  logic                err_q, err_d;

  logic [PC_WIDTH-1:0] branch_off;
  logic [PC_WIDTH-1:0] jump_tgt;

  // Signed cast sign-extends the 16-bit immediate; unsigned cast zero-extends.
  // Both truncate if PC_WIDTH < 16. Sums wrap modulo 2**PC_WIDTH.
  assign branch_off = PC_WIDTH'($signed(ir_q[15:0]));
  assign jump_tgt   = PC_WIDTH'(ir_q[15:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      pc_q       <= PC_WIDTH'(RESET_PC);
      ir_q       <= 32'h0;
      ir_pc_q    <= PC_WIDTH'(RESET_PC);
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        // Redirect lands on the same edge as an accepted fetch_req, so the
        // fetch that follows reads the redirected PC.
        if (bus.pc_we) begin
          case (bus.pc_sel)
            2'b01:   pc_d = pc_q + branch_off;
            2'b10:   pc_d = jump_tgt;
            default: pc_d = pc_q;
          endcase
        end
        if (bus.fetch_req) begin
          state_d = S_WAIT;
          cnt_d   = 4'(FETCH_WAIT);
        end
      end

      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
        if (bus.fetch_req || bus.pc_we) begin
          err_d = 1'b1;
        end
      end

      S_CAPTURE: begin
        ir_d       = bus.imem_instr;
        ir_pc_d    = pc_q;
        pc_d       = pc_q + PC_WIDTH'(1);
        ir_valid_d = 1'b1;
        state_d    = S_IDLE;
        if (bus.fetch_req || bus.pc_we) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.imem_pc  = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.err      = err_q;

endmodule
